// File: rtl/systolic_data_feeder.sv
// Issues consecutive unified_buffer row reads and skews the returned rows
// into a diagonal wavefront for the systolic array.
module systolic_data_feeder #(
    parameter int MATRIX_WIDTH    = 4,
    parameter int UB_READ_LATENCY = 3,
    parameter int ROW_CNT_WIDTH   = 16,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [ROW_CNT_WIDTH-1:0]     cmd_rows,
    output logic [ADDR_WIDTH-1:0]        ub_addr,
    output logic                         ub_en,
    input  logic [MATRIX_WIDTH-1:0][7:0] ub_read_port,
    output logic [MATRIX_WIDTH-1:0][7:0] sds_data,
    output logic [MATRIX_WIDTH-1:0]      sds_valid,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam int DRAIN_CYC = UB_READ_LATENCY + MATRIX_WIDTH - 1;
    localparam int DW        = $clog2(DRAIN_CYC);

    state_t                     state;
    logic [ROW_CNT_WIDTH-1:0]   left;
    logic [DW-1:0]              drain_cnt;
    logic [UB_READ_LATENCY-1:0] lat_pipe;
    logic                       tail;

    assign tail = lat_pipe[UB_READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ub_en     <= 1'b0;
            ub_addr   <= '0;
            left      <= '0;
            drain_cnt <= '0;
            lat_pipe  <= '0;
        end else if (enable) begin
            lat_pipe[0] <= ub_en;
            for (int k = 1; k < UB_READ_LATENCY; k++) begin
                lat_pipe[k] <= lat_pipe[k-1];
            end
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            ub_en     <= 1'b1;
                            ub_addr   <= cmd_addr;
                            left      <= cmd_rows - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (left != '0) begin
                        ub_addr <= ub_addr + 1'b1;
                        left    <= left - 1'b1;
                    end else begin
                        ub_en     <= 1'b0;
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    // Counts down exactly until the last column leaves the skew stage
                    if (drain_cnt == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Column 0 is presented the cycle the buffer data arrives
    assign sds_valid[0] = tail;
    assign sds_data[0]  = tail ? ub_read_port[0] : 8'h00;

    for (genvar j = 1; j < MATRIX_WIDTH; j++) begin : g_col
        logic [j-1:0]      v;
        logic [j-1:0][7:0] d;

        always_ff @(posedge clk) begin
            if (rst) begin
                v <= '0;
                d <= '0;
            end else if (enable) begin
                v[0] <= tail;
                d[0] <= tail ? ub_read_port[j] : 8'h00;
                for (int k = 1; k < j; k++) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
        end

        assign sds_valid[j] = v[j-1];
        assign sds_data[j]  = d[j-1];
    end

endmodule

// File: tb/tb_systolic_data_feeder.sv
// Bench for systolic_data_feeder: latency-3 buffer model plus a schedule-based
// reference indexed by enabled-cycle count.
module tb_systolic_data_feeder;

    localparam int N = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [15:0] cmd_rows = '0;
    logic [7:0]  ub_addr;
    logic        ub_en;
    logic [3:0][7:0] ub_read_port;
    logic [3:0][7:0] sds_data;
    logic [3:0]  sds_valid;
    logic        busy;
    logic        done;

    systolic_data_feeder dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
        .ub_addr(ub_addr), .ub_en(ub_en),
        .ub_read_port(ub_read_port),
        .sds_data(sds_data), .sds_valid(sds_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    bit [31:0] mem [256];
    bit [31:0] bp  [3];

    always @(posedge clk) begin
        if (enable) begin
            bp[0] <= mem[ub_addr];
            bp[1] <= bp[0];
            bp[2] <= bp[1];
        end
    end
    assign ub_read_port = bp[2];

    bit [31:0] exp_dat  [N];
    bit [3:0]  exp_vld  [N];
    bit [7:0]  exp_ad   [N];
    bit        exp_en   [N];
    bit        exp_busy [N];
    bit        exp_done [N];

    int ec = 0;
    int checks = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, ec);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            exp_dat[i] = '0; exp_vld[i] = '0; exp_ad[i] = '0;
            exp_en[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
        end
    endtask

    // Row k goes out at a+k; column j of that row shows at a+k+3+j
    task automatic sched(int a, bit [7:0] addr, int r);
        bit [7:0]  ad;
        bit [31:0] row;
        if (r == 0) begin
            exp_done[a] = 1;
            return;
        end
        for (int k = 0; k < r; k++) begin
            ad = addr + 8'(k);
            row = mem[ad];
            exp_en[a+k] = 1;
            exp_ad[a+k] = ad;
            for (int j = 0; j < 4; j++) begin
                exp_vld[a+k+3+j][j] = 1'b1;
                exp_dat[a+k+3+j][j*8 +: 8] = row[j*8 +: 8];
            end
        end
        for (int c = a; c <= a + r + 5; c++) exp_busy[c] = 1;
        exp_done[a+r+6] = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            clear_model();
            ec++;
        end else if (enable) begin
            if (cmd_valid && !exp_busy[ec])
                sched(ec + 1, cmd_addr, int'(cmd_rows));
            ec++;
        end
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(!exp_busy[ec]));
        check("busy", 32'(busy), 32'(exp_busy[ec]));
        check("done", 32'(done), 32'(exp_done[ec]));
        check("ub_en", 32'(ub_en), 32'(exp_en[ec]));
        if (exp_en[ec]) check("ub_addr", 32'(ub_addr), 32'(exp_ad[ec]));
        check("sds_valid", 32'(sds_valid), 32'(exp_vld[ec]));
        check("sds_data", sds_data, exp_dat[ec]);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(bit [7:0] a, int r);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rows  = 16'(r);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // single row
        mem[5] = 32'h13121110;
        issue(8'd5, 1);
        ticks(10);

        // wavefront
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++)
                mem[i][j*8 +: 8] = 8'(i * j);
        issue(8'd0, 16);
        ticks(28);

        // zero rows
        issue(8'd9, 0);
        ticks(5);

        // stall mid-issue plus address wrap
        mem[255] = 32'hDDCCBBAA;
        mem[0]   = 32'h44332211;
        mem[1]   = 32'h88776655;
        issue(8'd255, 3);
        tick();
        enable = 1'b0;
        ticks(3);
        enable = 1'b1;
        ticks(14);

        // abort during drain, then a normal command with cmd_valid spam
        issue(8'd20, 4);
        ticks(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(3);
        issue(8'd7, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 8'd40;
        cmd_rows  = 16'd2;
        ticks(4);
        cmd_valid = 1'b0;
        ticks(16);

        // randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 900; i++) begin
            cmd_valid = ($urandom % 4) == 0;
            cmd_addr  = 8'($urandom);
            cmd_rows  = 16'($urandom_range(0, 12));
            enable    = ($urandom % 8) != 0;
            rst       = ($urandom % 300) == 0;
            tick();
        end
        rst = 1'b0;
        enable = 1'b1;
        cmd_valid = 1'b0;
        ticks(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
